// File: rtl/vx_mem_if.sv
// Vortex top-level memory port: request stream from the cache side and
// tagged read responses back from the memory side.
interface vx_mem_if #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8
);
    logic                    mem_req_valid;
    logic                    mem_req_rw;
    logic [DATA_WIDTH/8-1:0] mem_req_byteen;
    logic [ADDR_WIDTH-1:0]   mem_req_addr;
    logic [DATA_WIDTH-1:0]   mem_req_data;
    logic [TAG_WIDTH-1:0]    mem_req_tag;
    logic                    mem_req_ready;

    logic                    mem_rsp_valid;
    logic [DATA_WIDTH-1:0]   mem_rsp_data;
    logic [TAG_WIDTH-1:0]    mem_rsp_tag;
    logic                    mem_rsp_ready;

    modport master (
        output mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag,
        input  mem_req_ready,
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        output mem_rsp_ready
    );

    modport slave (
        input  mem_req_valid, mem_req_rw, mem_req_byteen, mem_req_addr,
               mem_req_data, mem_req_tag,
        output mem_req_ready,
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag,
        input  mem_rsp_ready
    );
endinterface

// File: rtl/vx_mem_responder.sv
// Backing memory below the Vortex memory port: byte-masked writes, fixed-latency
// in-order tagged reads, credit-limited outstanding reads.
module vx_mem_responder #(
    parameter int DATA_WIDTH = 512,
    parameter int ADDR_WIDTH = 26,
    parameter int TAG_WIDTH  = 8,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4,
    parameter int QUEUE_SIZE = 8
) (
    input  logic     clk,
    input  logic     reset,
    vx_mem_if.slave  mem_if,
    output logic     busy
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = $clog2(QUEUE_SIZE);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    typedef struct packed {
        logic valid;
        rsp_t rsp;
    } pipe_t;

    logic                  reset_q;
    logic [CNT_W-1:0]      pending;
    logic                  req_fire, rd_fire, wr_fire, rsp_fire;
    logic [DEPTH_LOG2-1:0] line_idx;
    pipe_t                 pipe_in, pipe_out;

    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    assign mem_if.mem_req_ready = !reset_q && (pending < CNT_W'(QUEUE_SIZE));
    assign req_fire = mem_if.mem_req_valid && mem_if.mem_req_ready;
    assign rd_fire  = req_fire && !mem_if.mem_req_rw;
    assign wr_fire  = req_fire && mem_if.mem_req_rw;
    assign rsp_fire = mem_if.mem_rsp_valid && mem_if.mem_rsp_ready;
    assign line_idx = mem_if.mem_req_addr[DEPTH_LOG2-1:0];

    generate
        if (ADDR_WIDTH > DEPTH_LOG2) begin : g_addr_wrap
            logic unused_addr_hi;
            assign unused_addr_hi = ^mem_if.mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    endgenerate

    // ---------------- storage ----------------
    logic [DATA_WIDTH-1:0] storage [DEPTH];

    // NOTE: the storage array has no reset branch; contents must survive reset
    // and a reset loop over the array would stop it mapping onto RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < BYTES; i++) begin
                if (mem_if.mem_req_byteen[i])
                    storage[line_idx][i*8 +: 8] <= mem_if.mem_req_data[i*8 +: 8];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and infers a latch.
    always_comb begin
        pipe_in          = '0;
        pipe_in.valid    = rd_fire;
        pipe_in.rsp.tag  = mem_if.mem_req_tag;
        pipe_in.rsp.data = storage[line_idx];
    end

    // ---------------- latency pipeline ----------------
    // The FIFO write edge is the last latency stage, so LATENCY-1 registers here.
    generate
        if (LATENCY == 1) begin : g_no_pipe
            assign pipe_out = pipe_in;
        end else begin : g_pipe
            pipe_t stages [LATENCY-1];

            // NOTE: sequential state uses non-blocking assignments so every stage
            // samples its predecessor's pre-edge value.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY-1; i++) stages[i] <= '0;
                end else begin
                    stages[0] <= pipe_in;
                    for (int i = 1; i < LATENCY-1; i++) stages[i] <= stages[i-1];
                end
            end

            assign pipe_out = stages[LATENCY-2];
        end
    endgenerate

    // ---------------- response FIFO ----------------
    rsp_t             fifo_mem [QUEUE_SIZE];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_wr;

    assign fifo_wr = pipe_out.valid;

    always_ff @(posedge clk) begin
        if (fifo_wr) fifo_mem[wr_ptr] <= pipe_out.rsp;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (fifo_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (rsp_fire) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + CNT_W'(fifo_wr) - CNT_W'(rsp_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fifo_no_overflow: assert (!(fifo_wr && !rsp_fire &&
                                        fifo_count == CNT_W'(QUEUE_SIZE)));
        end
    end

    // Outputs are forced to zero while empty so reset leaves a clean bus.
    assign mem_if.mem_rsp_valid = (fifo_count != '0);
    assign mem_if.mem_rsp_data  = mem_if.mem_rsp_valid ? fifo_mem[rd_ptr].data : '0;
    assign mem_if.mem_rsp_tag   = mem_if.mem_rsp_valid ? fifo_mem[rd_ptr].tag  : '0;

    // ---------------- read credits ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({rd_fire, rsp_fire})
                2'b10:   pending <= pending + 1'b1;
                2'b01:   pending <= pending - 1'b1;
                default: pending <= pending;
            endcase
        end
    end

    assign busy = (pending != '0);
endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: writes, partial writes, address wrap,
// credit backpressure, simultaneous fires and reset mid-flight.
module tb_vx_mem_responder;
    localparam int DW    = 512;
    localparam int AW    = 26;
    localparam int TW    = 8;
    localparam int BYTES = DW / 8;

    logic clk = 1'b0;
    logic reset;
    logic busy;

    always #5 clk = ~clk;

    vx_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    vx_mem_responder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW),
        .DEPTH_LOG2(10), .LATENCY(4), .QUEUE_SIZE(8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .mem_if (bus.slave),
        .busy   (busy)
    );

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } exp_t;

    int            checks = 0;
    int            errors = 0;
    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [1024];
    bit            last_req_fire;
    int            rsp_seen = 0;

    localparam logic [DW-1:0] PAT_A5   = {64{8'hA5}};
    localparam logic [DW-1:0] PAT_PART = {{63{8'hA5}}, 8'h11};
    localparam logic [DW-1:0] PAT_BEEF = {16{32'hDEADBEEF}};

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic idle();
        bus.mem_req_valid  = 1'b0;
        bus.mem_req_rw     = 1'b0;
        bus.mem_req_byteen = '0;
        bus.mem_req_addr   = '0;
        bus.mem_req_data   = '0;
        bus.mem_req_tag    = '0;
    endtask

    task automatic drive(input bit rw, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [BYTES-1:0] be,
                         input logic [TW-1:0] tag);
        bus.mem_req_valid  = 1'b1;
        bus.mem_req_rw     = rw;
        bus.mem_req_addr   = addr;
        bus.mem_req_data   = data;
        bus.mem_req_byteen = be;
        bus.mem_req_tag    = tag;
    endtask

    // Called at a negedge: records what fires on the coming posedge, then advances.
    task automatic step();
        logic [9:0] idx;
        exp_t       e;
        idx           = bus.mem_req_addr[9:0];
        last_req_fire = bus.mem_req_valid && bus.mem_req_ready;
        if (last_req_fire && bus.mem_req_rw) begin
            for (int i = 0; i < BYTES; i++)
                if (bus.mem_req_byteen[i])
                    model_mem[idx][i*8 +: 8] = bus.mem_req_data[i*8 +: 8];
        end else if (last_req_fire) begin
            exp_q.push_back('{bus.mem_req_tag, model_mem[idx]});
        end
        if (bus.mem_rsp_valid && bus.mem_rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_tag", bus.mem_rsp_tag, e.tag);
                check("rsp_data", bus.mem_rsp_data, e.data);
            end
        end
        @(negedge clk);
    endtask

    task automatic send(input bit rw, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [BYTES-1:0] be,
                        input logic [TW-1:0] tag);
        int n;
        drive(rw, addr, data, be, tag);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_req_fire && n < 20);
        if (!last_req_fire) check("send_timeout", 0, 1);
        idle();
    endtask

    task automatic read_latency(input string name, input logic [AW-1:0] addr,
                                input logic [TW-1:0] tag, input logic [DW-1:0] exp);
        int lat;
        send(1'b0, addr, '0, '0, tag);
        lat = 1;
        while (!bus.mem_rsp_valid && lat < 16) begin
            step();
            lat++;
        end
        check({name, "_latency"}, lat, 4);
        check({name, "_data"}, bus.mem_rsp_data, exp);
        check({name, "_tag"}, bus.mem_rsp_tag, tag);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nxt;
        int base;
        reset = 1'b1;
        idle();
        bus.mem_rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", bus.mem_req_ready, 0);
        check("rst_rsp_valid", bus.mem_rsp_valid, 0);
        check("rst_rsp_data", bus.mem_rsp_data, 0);
        check("rst_rsp_tag", bus.mem_rsp_tag, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        check("ready_still_low", bus.mem_req_ready, 0);
        @(negedge clk);
        check("ready_after_reset", bus.mem_req_ready, 1);

        // Full write then read back.
        send(1'b1, 26'h5, PAT_A5, '1, 8'h00);
        read_latency("full", 26'h5, 8'h3C, PAT_A5);

        // Byte-0 write over the A5 line; other bytes of the data bus must be ignored.
        send(1'b1, 26'h5, {{63{8'hFF}}, 8'h11}, 64'h1, 8'h00);
        read_latency("partial", 26'h5, 8'h41, PAT_PART);

        // Zero byte enables leave the line untouched.
        send(1'b1, 26'h5, '0, '0, 8'h00);
        read_latency("noop_write", 26'h5, 8'h42, PAT_PART);

        // 0x405 aliases line 0x5.
        send(1'b1, 26'h405, PAT_BEEF, '1, 8'h00);
        read_latency("wrap", 26'h5, 8'h43, PAT_BEEF);

        // Backpressure: 10 reads against an 8-deep credit budget.
        for (int i = 0; i < 10; i++)
            send(1'b1, 26'h20 + i, {16{32'hC0DE0000 + i}}, '1, 8'h00);
        bus.mem_rsp_ready = 1'b0;
        nxt = 0;
        for (int c = 0; c < 12; c++) begin
            if (nxt < 10) drive(1'b0, 26'h20 + nxt, '0, '0, 8'h80 + nxt);
            else idle();
            step();
            if (last_req_fire) nxt++;
        end
        check("bp_fired", nxt, 8);
        check("bp_ready_low", bus.mem_req_ready, 0);
        check("bp_busy", busy, 1);
        check("bp_rsp_valid", bus.mem_rsp_valid, 1);
        check("bp_head_tag", bus.mem_rsp_tag, 8'h80);
        step();
        check("bp_hold_tag", bus.mem_rsp_tag, 8'h80);
        check("bp_hold_data", bus.mem_rsp_data, {16{32'hC0DE0000}});
        bus.mem_rsp_ready = 1'b1;
        base = rsp_seen;
        step();
        check("bp_ready_after_rsp", bus.mem_req_ready, 1);
        for (int c = 1; c < 10; c++) begin
            if (nxt < 10) drive(1'b0, 26'h20 + nxt, '0, '0, 8'h80 + nxt);
            else idle();
            step();
            if (last_req_fire) nxt++;
        end
        idle();
        check("bp_rsp_per_cycle", rsp_seen - base, 10);
        check("bp_all_issued", nxt, 10);
        check("bp_queue_empty", exp_q.size(), 0);
        check("bp_idle", busy, 0);

        // Read fire and response fire in the same cycle with 3 outstanding.
        bus.mem_rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(1'b0, 26'h20 + i, '0, '0, 8'h90 + i);
        repeat (5) step();
        check("sim_pending_before", dut.pending, 3);
        check("sim_rsp_valid", bus.mem_rsp_valid, 1);
        bus.mem_rsp_ready = 1'b1;
        drive(1'b0, 26'h23, '0, '0, 8'h93);
        base = rsp_seen;
        step();
        idle();
        check("sim_req_fired", last_req_fire, 1);
        check("sim_rsp_fired", rsp_seen - base, 1);
        check("sim_pending_after", dut.pending, 3);
        check("sim_ready", bus.mem_req_ready, 1);
        nxt = 0;
        while (exp_q.size() > 0 && nxt < 20) begin
            step();
            nxt++;
        end
        check("sim_drained", exp_q.size(), 0);
        check("sim_idle", busy, 0);

        // Reset with 4 reads in flight: all dropped, storage kept.
        bus.mem_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(1'b0, 26'h20 + i, '0, '0, 8'hA0 + i);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", bus.mem_rsp_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", bus.mem_req_ready, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.mem_rsp_ready = 1'b1;
        base = rsp_seen;
        repeat (10) step();
        check("no_stale_rsp", rsp_seen - base, 0);
        read_latency("post_reset", 26'h5, 8'hB0, PAT_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
